// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler
//   Reservation station and issue scheduler for the single combinational ALU.
//   Dispatched ALU-class instructions are buffered until both operands are
//   known. Missing operands are captured from the ALU and LSB broadcast buses.
//   Each cycle, the lowest-index ready entry is issued to the ALU through
//   registered outputs.
//
// Ports
//   clk, rst (sync, active-low), rdy (global enable), in_flush (clear all)
//   in_valid/in_op/in_value1/in_tag1/in_value2/in_tag2/in_imm/in_pc/in_rob_tag
//     : dispatch write port (tag 0 = operand already valid)
//   out_full       : all entries occupied (registered valid bits only)
//   cdb_alu_*      : ALU result broadcast (tag 0 = idle)
//   cdb_lsb_*      : LSB result broadcast (tag 0 = idle)
//   out_op/out_value1/out_value2/out_imm/out_pc/out_rob_tag
//     : registered issue to the ALU; out_op = 0 (NOP) when nothing issues
module alu_issue_scheduler #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_flush,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_value1,
  input  logic [TAG_W-1:0]  in_tag1,
  input  logic [DATA_W-1:0] in_value2,
  input  logic [TAG_W-1:0]  in_tag2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_rob_tag,
  output logic              out_full,
  input  logic [TAG_W-1:0]  cdb_alu_tag,
  input  logic [DATA_W-1:0] cdb_alu_value,
  input  logic [TAG_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_lsb_value,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_value1,
  output logic [DATA_W-1:0] out_value2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [TAG_W-1:0]  out_rob_tag
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  // Capture a broadcast value into a waiting operand. A tag of 0 never
  // matches, so an operand that is already valid is never overwritten.
  function automatic opnd_t snoop(input opnd_t o,
                                  input logic [TAG_W-1:0]  at,
                                  input logic [DATA_W-1:0] av,
                                  input logic [TAG_W-1:0]  lt,
                                  input logic [DATA_W-1:0] lv);
    opnd_t r;
    r = o;
    if (o.tag != '0) begin
      if (o.tag == at) begin
        r.tag = '0;
        r.val = av;
      end else if (o.tag == lt) begin
        r.tag = '0;
        r.val = lv;
      end
    end
    return r;
  endfunction

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [OP_W-1:0]    op_q   [ENTRIES];
  logic [OP_W-1:0]    op_d   [ENTRIES];
  opnd_t              opa_q  [ENTRIES];
  opnd_t              opa_d  [ENTRIES];
  opnd_t              opb_q  [ENTRIES];
  opnd_t              opb_d  [ENTRIES];
  logic [DATA_W-1:0]  imm_q  [ENTRIES];
  logic [DATA_W-1:0]  imm_d  [ENTRIES];
  logic [DATA_W-1:0]  pc_q   [ENTRIES];
  logic [DATA_W-1:0]  pc_d   [ENTRIES];
  logic [TAG_W-1:0]   rob_q  [ENTRIES];
  logic [TAG_W-1:0]   rob_d  [ENTRIES];

  logic [OP_W-1:0]   out_op_q,  out_op_d;
  logic [DATA_W-1:0] out_v1_q,  out_v1_d;
  logic [DATA_W-1:0] out_v2_q,  out_v2_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [DATA_W-1:0] out_pc_q,  out_pc_d;
  logic [TAG_W-1:0]  out_rob_q, out_rob_d;

  logic [ENTRIES-1:0] ready;
  logic               issue_en;
  logic [IDX_W-1:0]   issue_idx;
  logic               alloc_en;
  logic [IDX_W-1:0]   alloc_idx;

  assign out_full    = &valid_q;
  assign out_op      = out_op_q;
  assign out_value1  = out_v1_q;
  assign out_value2  = out_v2_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;
  assign out_rob_tag = out_rob_q;

  // Issue and allocation choices both look only at pre-edge state; an
  // issuing entry is valid and therefore never the allocation target.
  always_comb begin
    ready     = '0;
    issue_en  = 1'b0;
    issue_idx = '0;
    alloc_en  = 1'b0;
    alloc_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ready[i] = valid_q[i] && (opa_q[i].tag == '0) && (opb_q[i].tag == '0);
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!issue_en && ready[i]) begin
        issue_en  = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!alloc_en && !valid_q[i]) begin
        alloc_en  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    rob_d     = rob_q;
    out_op_d  = '0;
    out_v1_d  = '0;
    out_v2_d  = '0;
    out_imm_d = '0;
    out_pc_d  = '0;
    out_rob_d = '0;
    if (in_flush) begin
      valid_d = '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (valid_q[i]) begin
          opa_d[i] = snoop(opa_q[i], cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
          opb_d[i] = snoop(opb_q[i], cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
        end
      end
      if (issue_en) begin
        valid_d[issue_idx] = 1'b0;
        out_op_d  = op_q[issue_idx];
        out_v1_d  = opa_q[issue_idx].val;
        out_v2_d  = opb_q[issue_idx].val;
        out_imm_d = imm_q[issue_idx];
        out_pc_d  = pc_q[issue_idx];
        out_rob_d = rob_q[issue_idx];
      end
      if (in_valid && alloc_en) begin
        valid_d[alloc_idx] = 1'b1;
        op_d[alloc_idx]    = in_op;
        opa_d[alloc_idx]   = snoop('{tag: in_tag1, val: in_value1},
                                   cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
        opb_d[alloc_idx]   = snoop('{tag: in_tag2, val: in_value2},
                                   cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
        imm_d[alloc_idx]   = in_imm;
        pc_d[alloc_idx]    = in_pc;
        rob_d[alloc_idx]   = in_rob_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= '0;
      out_op_q  <= '0;
      out_v1_q  <= '0;
      out_v2_q  <= '0;
      out_imm_q <= '0;
      out_pc_q  <= '0;
      out_rob_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        op_q[i]  <= '0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        rob_q[i] <= '0;
      end
    end else if (rdy) begin
      valid_q   <= valid_d;
      out_op_q  <= out_op_d;
      out_v1_q  <= out_v1_d;
      out_v2_q  <= out_v2_d;
      out_imm_q <= out_imm_d;
      out_pc_q  <= out_pc_d;
      out_rob_q <= out_rob_d;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        op_q[i]  <= op_d[i];
        opa_q[i] <= opa_d[i];
        opb_q[i] <= opb_d[i];
        imm_q[i] <= imm_d[i];
        pc_q[i]  <= pc_d[i];
        rob_q[i] <= rob_d[i];
      end
    end
  end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- Reservation station and issue scheduler for the single combinational ALU.
- Buffers decoded ALU-class instructions from dispatch and captures missing operands from the two broadcast buses (ALU result, LSB result).
- Each cycle, picks one ready entry and drives registered operands, op, imm, pc and ROB tag into the ALU.
- Sits between dispatch/rename and the ALU; the ALU result bus feeds back into this block for wakeup.

Parameters:
ENTRIES, 8, number of station entries (power of two, >=2)
TAG_W, 4, ROB tag width; tag 0 = "no tag / operand ready"
OP_W, 6, internal opcode width; op 0 = NOP
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
rdy  in  1  global enable; 0 = freeze all state
in_flush  in  1  misprediction flush; clears all entries
in_valid  in  1  dispatch writes an instruction this cycle
in_op  in  OP_W  internal opcode
in_value1  in  DATA_W  operand 1 value, meaningful when in_tag1==0
in_tag1  in  TAG_W  operand 1 producer tag, 0 = ready
in_value2  in  DATA_W  operand 2 value
in_tag2  in  TAG_W  operand 2 producer tag
in_imm  in  DATA_W  immediate
in_pc  in  DATA_W  instruction pc
in_rob_tag  in  TAG_W  destination ROB tag (nonzero)
out_full  out  1  combinational: all entries valid
cdb_alu_tag  in  TAG_W  ALU broadcast tag, 0 = none
cdb_alu_value  in  DATA_W  ALU broadcast value
cdb_lsb_tag  in  TAG_W  LSB broadcast tag, 0 = none
cdb_lsb_value  in  DATA_W  LSB broadcast value
out_op  out  OP_W  to ALU; NOP when nothing issues
out_value1  out  DATA_W  to ALU
out_value2  out  DATA_W  to ALU
out_imm  out  DATA_W  to ALU
out_pc  out  DATA_W  to ALU
out_rob_tag  out  TAG_W  to ALU

Behaviour:
- Priority per rising edge: rst==0 > rdy==0 > in_flush > normal operation.
- Reset: all entry valid bits 0; out_op=NOP; all other outputs 0. out_full=0.
- rdy==0: every register, including outputs, holds its value. Inputs are ignored.
- in_flush (rdy==1): all valid bits cleared, out_op<=NOP, other outputs <=0. A simultaneous in_valid is dropped.
- Allocation: when in_valid and !out_full, write the lowest-index entry whose valid bit is 0 in pre-edge state.
  - An entry issuing this same edge is not reusable until the next cycle.
  - in_valid while out_full is a protocol violation; it is dropped and state is unchanged.
- Allocation bypass: if in_tagN matches a nonzero cdb tag in the same cycle, store that cdb value and set tagN=0. The ALU bus is checked before the LSB bus; both matching cannot occur.
- Wakeup: for every valid entry and each operand with tagN!=0 equal to a nonzero cdb tag, capture the value and clear tagN at the edge.
- Ready: valid && tag1==0 && tag2==0, evaluated on registered (pre-edge) state.
  - An entry woken at edge E is first eligible to issue at edge E+1; there is no same-cycle wakeup-to-issue.
- Select: the lowest-index ready entry.
  - At the edge, out_* <= entry fields and the entry's valid <= 0.
  - If no entry is ready: out_op<=NOP, others <=0.
  - Exactly one issue per cycle.
- Latency: an instruction allocated with both operands ready at edge E appears on out_* after edge E+1.
- out_full is derived from the registered valid bits only; an issue in the current cycle does not relieve it.
- Tag 0 never wakes anything. Operands whose tag is already 0 are never overwritten.

Test Plan:
- Reset with rst=0 for 2 cycles; dispatch ADD (tags 0, v1=5, v2=7, rob 3) at edge E -> after E+1: out_op=ADD, out_value1=5, out_value2=7, out_rob_tag=3; after E+2: out_op=NOP.
- Dispatch SUB with tag1=6; hold 3 cycles -> out_op stays NOP. Then cdb_lsb_tag=6, value=0x10 at edge E -> SUB issues after E+1 with out_value1=0x10.
- Dispatch with tag2=4 while cdb_alu_tag=4, value=9 in the same cycle -> bypass captured; issues the next cycle with out_value2=9.
- Fill all 8 entries with tag1=2 -> out_full=1; a 9th in_valid is dropped. Broadcast tag 2 -> entries 0..7 issue in index order on 8 consecutive cycles, then NOP.
- Fill 3 entries, assert in_flush together with in_valid -> all cleared, out_op=NOP, out_full=0. A later broadcast of the old tags issues nothing.
- rdy=0 while an entry is ready -> out_* and the entry are frozen. rdy=1 -> issue resumes the next edge. rst=0 mid-stream -> all entries empty, out_op=NOP.
